// File: rtl/cpu_host.sv
`default_nettype none
// ============================================================================
// cpu_host : loads a memory image, kicks the core, waits for done (with
//            timeout) and streams the result window back out.
// Revision : 1.0
// ============================================================================
module cpu_host #(
  parameter int LOAD_N   = 64,
  parameter int RES_BASE = 64,
  parameter int RES_N    = 32,
  parameter int TMO      = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  output logic       req,
  input  logic       done,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic       busy,
  output logic       job_done,
  output logic       timeout
);

  localparam logic [8:0]  c_LOAD_LAST = 9'(LOAD_N - 1);
  localparam logic [8:0]  c_RES_LAST  = 9'(RES_N - 1);
  localparam logic [7:0]  c_RES_BASE  = 8'(RES_BASE);
  localparam logic [15:0] c_TMO_LAST  = 16'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_idx, w_idx_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic        r_job_done, w_job_done_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_job_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_job_done <= w_job_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = r_timeout;
    w_job_done_nxt = 1'b0;
    load_ready     = 1'b0;
    mem_wr_en      = 1'b0;
    mem_addr       = 8'd0;
    mem_wr_data    = 8'd0;
    req            = 1'b0;
    res_valid      = 1'b0;
    res_data       = 8'd0;
    busy           = 1'b0;

    unique case (r_state)
      S_IDLE, S_ERR: begin
        if (start) begin
          w_state_nxt   = S_LOAD;
          w_idx_nxt     = 9'd0;
          w_timeout_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        mem_addr   = r_idx[7:0];
        if (load_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = load_data;
          w_idx_nxt   = r_idx + 9'd1;
          if (r_idx == c_LOAD_LAST) begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        busy        = 1'b1;
        req         = 1'b1;
        w_cnt_nxt   = 16'd0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // done on the last allowed cycle still counts as success
        if (done) begin
          w_state_nxt = S_DRAIN;
          w_idx_nxt   = 9'd0;
        end else if (r_cnt == c_TMO_LAST) begin
          w_state_nxt   = S_ERR;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        mem_addr  = c_RES_BASE + r_idx[7:0];
        res_valid = 1'b1;
        res_data  = mem_rd_data;
        if (res_ready) begin
          w_idx_nxt = r_idx + 9'd1;
          if (r_idx == c_RES_LAST) begin
            w_state_nxt    = S_IDLE;
            w_job_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign job_done = r_job_done;
  assign timeout  = r_timeout;

endmodule
`default_nettype wire
